// File: rtl/uart_rx_fifo.sv
// Receive buffer between rx_unit and the CPU bus bridge: captures each byte flagged by rx_unit,
// acknowledges it with a one-cycle over_read pulse, and offers FWFT read data, status and an irq.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int THRESH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_rs,
    output logic          rx_over_read,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          ovr_clr,
    output logic          irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);

    state_t        state;
    state_t        next_state;
    logic          rs_meta;
    logic          rs_s;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          drop;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [7:0]    mem [DEPTH];

    // rs is launched from a derived clock edge, so it is brought in through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta <= 1'b0;
            rs_s    <= 1'b0;
        end else begin
            rs_meta <= rx_rs;
            rs_s    <= rs_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // WAIT holds until rs drops so a single byte is never pushed twice.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (rs_s) next_state = ACK;
            ACK:     next_state = WAIT;
            WAIT:    if (!rs_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        push_req     = (state == IDLE) && rs_s;
        rx_over_read = (state == ACK);
    end

    // A pop on the same edge frees the slot, so a push into a full FIFO is then accepted.
    always_comb begin
        do_pop  = rd_en && !empty;
        do_push = push_req && (!full || do_pop);
        drop    = push_req && full && !do_pop;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (do_push && !do_pop) begin
            count <= count + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count <= count - (AW+1)'(1);
        end
    end

    // A drop on the same edge as ovr_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    always_comb begin
        rd_data = mem[rptr];
        empty   = (count == '0);
        full    = (count == DEPTH_C);
        irq     = (count >= THRESH_C) || overrun;
    end

endmodule
